// File: rtl/wf_multi_sampler_pkg.sv
// ---------------------------------------------------------------------------
// wf_multi_sampler_pkg
// Shared definitions for the multi-channel waterfall I/Q sampler:
//   - wfMode_e  : per-channel capture mode encodings (cfg_mode values)
//   - wfState_e : per-channel capture FSM states
//   - chanBits  : index width for a channel count, never less than 1
// No ports (package).
// ---------------------------------------------------------------------------
package wf_multi_sampler_pkg;

    typedef enum logic [1:0] {
        WF_MODE_OFF     = 2'd0,
        WF_MODE_ONESHOT = 2'd1,
        WF_MODE_CONTIN  = 2'd2,
        WF_MODE_SYNC    = 2'd3
    } wfMode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_FILL      = 2'd2,
        ST_DONE      = 2'd3
    } wfState_e;

    // A single channel still needs a 1-bit index so port widths stay legal.
    function automatic int chanBits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wf_multi_sampler_rr_arb.sv
// ---------------------------------------------------------------------------
// wf_multi_sampler_rr_arb
// Round-robin arbiter: picks one requester per cycle, searching from the
// index just after the most recent grant so every requester is served
// within N-1 cycles of any competing grant.
// Ports:
//   i_clk       clock (posedge)
//   i_rst_n     synchronous active-low reset
//   i_req       N request lines
//   o_gnt       one-hot grant (all zero when nothing requests)
//   o_gnt_idx   binary index of the granted requester
//   o_gnt_valid at least one request is being granted this cycle
// ---------------------------------------------------------------------------
module wf_multi_sampler_rr_arb
    import wf_multi_sampler_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = chanBits(N)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N-1:0]    i_req,
    output logic [N-1:0]    o_gnt,
    output logic [IDXW-1:0] o_gnt_idx,
    output logic            o_gnt_valid
);

    logic [IDXW-1:0] r_last;
    logic [IDXW-1:0] w_cand;
    logic            w_found;

    // Walk the requesters starting one past the last winner; the first
    // active one wins. Reset points r_last at N-1 so channel 0 goes first.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDXW'((int'(r_last) + k) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_gnt_idx     = w_cand;
            end
        end
    end

    assign o_gnt_valid = |i_req;

    // Remember the winner so the next search starts after it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= IDXW'(N - 1);
        end else if (o_gnt_valid) begin
            r_last <= o_gnt_idx;
        end
    end

endmodule

// File: rtl/wf_multi_sampler.sv
// ---------------------------------------------------------------------------
// wf_multi_sampler
// N-channel waterfall I/Q capture. Each channel owns a capture FSM, a
// sample-skip counter, a one-entry holding register and a write pointer.
// Kept samples wait in their holding register until the round-robin
// arbiter grants the single write port of a shared RAM addressed {ch, ptr}.
// Ports:
//   i_adc_clk     sole clock
//   i_rst_n       synchronous active-low reset
//   i_in_strobe   per-channel sample valid pulse
//   i_in_i/i_in_q per-channel I/Q samples, channel c at [c*IW +: IW]
//   i_cfg_we      latch i_cfg_mode/i_cfg_skip into channel i_cfg_ch
//   i_cfg_ch      channel addressed by i_cfg_we and i_arm
//   i_cfg_mode    0 OFF, 1 ONESHOT, 2 CONTIN, 3 SYNC
//   i_cfg_skip    keep one of every i_cfg_skip+1 strobes
//   i_arm         restart channel i_cfg_ch with its configured mode/skip
//   i_sync_in     shared start pulse for SYNC channels
//   i_rd_en/i_rd_ch/i_rd_addr  read request
//   o_rd_data     {I,Q}, one cycle after i_rd_en, held otherwise
//   o_rd_valid    i_rd_en delayed one cycle
//   o_full        channel finished DEPTH writes (ONESHOT/SYNC)
//   o_overrun     sticky: a kept sample was dropped
//   o_wr_ptr_all  next write address per channel, channel c at [c*AW +: AW]
// ---------------------------------------------------------------------------
module wf_multi_sampler
    import wf_multi_sampler_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int IW    = 16,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = chanBits(NCH)
) (
    input  logic              i_adc_clk,
    input  logic              i_rst_n,
    input  logic [NCH-1:0]    i_in_strobe,
    input  logic [NCH*IW-1:0] i_in_i,
    input  logic [NCH*IW-1:0] i_in_q,
    input  logic              i_cfg_we,
    input  logic [CW-1:0]     i_cfg_ch,
    input  logic [1:0]        i_cfg_mode,
    input  logic [7:0]        i_cfg_skip,
    input  logic              i_arm,
    input  logic              i_sync_in,
    input  logic              i_rd_en,
    input  logic [CW-1:0]     i_rd_ch,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [2*IW-1:0]   o_rd_data,
    output logic              o_rd_valid,
    output logic [NCH-1:0]    o_full,
    output logic [NCH-1:0]    o_overrun,
    output logic [NCH*AW-1:0] o_wr_ptr_all
);

    localparam int RAMD = NCH * DEPTH;

    logic [NCH-1:0]    w_holdValid;
    logic [2*IW-1:0]   w_holdData [NCH];
    logic [AW-1:0]     w_ptr      [NCH];
    logic [NCH-1:0]    w_armVec;
    logic [NCH-1:0]    w_gnt;
    logic [CW-1:0]     w_gntIdx;
    logic              w_gntValid;
    logic              w_we;
    logic [CW+AW-1:0]  w_wrAddr;
    logic [2*IW-1:0]   w_wrData;

    logic [2*IW-1:0]   r_ram [RAMD];
    logic [2*IW-1:0]   r_rdData;
    logic              r_rdValid;

    wf_multi_sampler_rr_arb #(
        .N    (NCH),
        .IDXW (CW)
    ) u_arb (
        .i_clk       (i_adc_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (w_holdValid),
        .o_gnt       (w_gnt),
        .o_gnt_idx   (w_gntIdx),
        .o_gnt_valid (w_gntValid)
    );

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        wfState_e        r_state;
        wfState_e        w_nextState;
        wfMode_e         r_cfgMode;
        wfMode_e         r_runMode;
        wfMode_e         w_armMode;
        logic [7:0]      r_cfgSkip;
        logic [7:0]      r_runSkip;
        logic [7:0]      w_armSkip;
        logic [7:0]      r_cnt;
        logic            r_holdValid;
        logic [2*IW-1:0] r_holdData;
        logic [AW-1:0]   r_ptr;
        logic            r_full;
        logic            r_overrun;
        logic            w_sel;
        logic            w_armMe;
        logic            w_cfgMe;
        logic            w_window;
        logic            w_strobe;
        logic            w_keep;
        logic            w_gntMe;
        logic            w_lastWrite;
        logic [2*IW-1:0] w_sample;

        assign w_sel     = (i_cfg_ch == CW'(c));
        assign w_armMe   = i_arm && w_sel;
        assign w_cfgMe   = i_cfg_we && w_sel;
        // A config write in the arm cycle is what that arm should use.
        assign w_armMode = w_cfgMe ? wfMode_e'(i_cfg_mode) : r_cfgMode;
        assign w_armSkip = w_cfgMe ? i_cfg_skip : r_cfgSkip;
        // The sync_in cycle itself already accepts a strobe.
        assign w_window  = (r_state == ST_FILL) ||
                           ((r_state == ST_WAIT_SYNC) && i_sync_in);
        assign w_strobe  = i_in_strobe[c] && w_window && !w_armMe;
        assign w_keep    = w_strobe && (r_cnt == 8'd0);
        assign w_gntMe   = w_gnt[c];
        assign w_lastWrite = w_gntMe && (r_ptr == AW'(DEPTH - 1)) &&
                             (r_runMode != WF_MODE_CONTIN);
        assign w_sample  = {i_in_i[c*IW +: IW], i_in_q[c*IW +: IW]};

        // Capture FSM next state: arm always wins and picks the entry
        // state from the mode it is launched with.
        always_comb begin
            w_nextState = r_state;
            if (w_armMe) begin
                case (w_armMode)
                    WF_MODE_ONESHOT, WF_MODE_CONTIN: w_nextState = ST_FILL;
                    WF_MODE_SYNC:                    w_nextState = ST_WAIT_SYNC;
                    default:                         w_nextState = ST_IDLE;
                endcase
            end else begin
                case (r_state)
                    ST_WAIT_SYNC: if (i_sync_in)   w_nextState = ST_FILL;
                    ST_FILL:      if (w_lastWrite) w_nextState = ST_DONE;
                    default:      ;
                endcase
            end
        end

        // Channel state. Arm discards any pending or in-flight sample and
        // restarts the pointer; a sample kept in the final-write cycle of a
        // one-shot capture is simply discarded because the channel is done.
        always_ff @(posedge i_adc_clk) begin
            if (!i_rst_n) begin
                r_state     <= ST_IDLE;
                r_cfgMode   <= WF_MODE_OFF;
                r_runMode   <= WF_MODE_OFF;
                r_cfgSkip   <= '0;
                r_runSkip   <= '0;
                r_cnt       <= '0;
                r_holdValid <= 1'b0;
                r_holdData  <= '0;
                r_ptr       <= '0;
                r_full      <= 1'b0;
                r_overrun   <= 1'b0;
            end else begin
                r_state <= w_nextState;
                if (w_cfgMe) begin
                    r_cfgMode <= wfMode_e'(i_cfg_mode);
                    r_cfgSkip <= i_cfg_skip;
                end
                if (w_armMe) begin
                    r_runMode   <= w_armMode;
                    r_runSkip   <= w_armSkip;
                    r_cnt       <= '0;
                    r_holdValid <= 1'b0;
                    r_ptr       <= '0;
                    r_full      <= 1'b0;
                    r_overrun   <= 1'b0;
                end else begin
                    if (w_strobe) begin
                        r_cnt <= (r_cnt == r_runSkip) ? 8'd0 : r_cnt + 8'd1;
                    end
                    if (w_gntMe) begin
                        r_ptr <= r_ptr + AW'(1);
                    end
                    if (w_lastWrite) begin
                        r_full <= 1'b1;
                    end
                    if (w_keep && !w_lastWrite) begin
                        if (r_holdValid && !w_gntMe) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_holdValid <= 1'b1;
                            r_holdData  <= w_sample;
                        end
                    end else if (w_gntMe) begin
                        r_holdValid <= 1'b0;
                    end
                end
            end
        end

        assign w_holdValid[c]             = r_holdValid;
        assign w_holdData[c]              = r_holdData;
        assign w_ptr[c]                   = r_ptr;
        assign w_armVec[c]                = w_armMe;
        assign o_full[c]                  = r_full;
        assign o_overrun[c]               = r_overrun;
        assign o_wr_ptr_all[c*AW +: AW]   = r_ptr;
    end

    // A grant to a channel being re-armed in the same cycle is thrown away.
    assign w_we     = w_gntValid && !w_armVec[w_gntIdx];
    assign w_wrAddr = {w_gntIdx, w_ptr[w_gntIdx]};
    assign w_wrData = w_holdData[w_gntIdx];

    // Shared sample RAM write port; contents are not reset.
    always_ff @(posedge i_adc_clk) begin
        if (w_we) begin
            r_ram[w_wrAddr] <= w_wrData;
        end
    end

    // Registered read port. Non-blocking update gives read-first behaviour
    // when the same address is written in the same cycle.
    always_ff @(posedge i_adc_clk) begin
        if (!i_rst_n) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= i_rd_en;
            if (i_rd_en) begin
                r_rdData <= r_ram[{i_rd_ch, i_rd_addr}];
            end
        end
    end

    assign o_rd_data  = r_rdData;
    assign o_rd_valid = r_rdValid;

endmodule

// File: tb/tb_wf_multi_sampler.sv
// ---------------------------------------------------------------------------
// tb_wf_multi_sampler
// Directed bench for wf_multi_sampler with NCH=4, IW=16, DEPTH=16.
// Read-back expectations live in a vector table filled at the start; the
// multi-cycle corner cases are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_wf_multi_sampler;
    import wf_multi_sampler_pkg::*;

    localparam int NCH   = 4;
    localparam int IW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 2;
    localparam int NVEC  = 29;

    logic              clk;
    logic              rstN;
    logic [NCH-1:0]    inStrobe;
    logic [NCH*IW-1:0] inI;
    logic [NCH*IW-1:0] inQ;
    logic              cfgWe;
    logic [CW-1:0]     cfgCh;
    logic [1:0]        cfgMode;
    logic [7:0]        cfgSkip;
    logic              arm;
    logic              syncIn;
    logic              rdEn;
    logic [CW-1:0]     rdCh;
    logic [AW-1:0]     rdAddr;
    logic [2*IW-1:0]   rdData;
    logic              rdValid;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    overrun;
    logic [NCH*AW-1:0] wrPtrAll;

    typedef struct {
        logic [CW-1:0]   ch;
        logic [AW-1:0]   addr;
        logic [2*IW-1:0] expData;
    } rdVec_t;

    rdVec_t vecs [NVEC];
    int     passCount = 0;
    int     checkCount = 0;

    wf_multi_sampler #(
        .NCH   (NCH),
        .IW    (IW),
        .DEPTH (DEPTH)
    ) dut (
        .i_adc_clk    (clk),
        .i_rst_n      (rstN),
        .i_in_strobe  (inStrobe),
        .i_in_i       (inI),
        .i_in_q       (inQ),
        .i_cfg_we     (cfgWe),
        .i_cfg_ch     (cfgCh),
        .i_cfg_mode   (cfgMode),
        .i_cfg_skip   (cfgSkip),
        .i_arm        (arm),
        .i_sync_in    (syncIn),
        .i_rd_en      (rdEn),
        .i_rd_ch      (rdCh),
        .i_rd_addr    (rdAddr),
        .o_rd_data    (rdData),
        .o_rd_valid   (rdValid),
        .o_full       (full),
        .o_overrun    (overrun),
        .o_wr_ptr_all (wrPtrAll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    // One strobe on the channels in mask with the same I/Q everywhere,
    // followed by enough idle cycles to make the strobe spacing gap.
    task automatic applyStimulus(input logic [NCH-1:0] mask, input logic [IW-1:0] iVal,
                                 input logic [IW-1:0] qVal, input logic sync, input int gap);
        inStrobe = mask;
        inI      = {NCH{iVal}};
        inQ      = {NCH{qVal}};
        syncIn   = sync;
        tick();
        inStrobe = '0;
        syncIn   = 1'b0;
        for (int g = 1; g < gap; g++) tick();
    endtask

    task automatic configure(input int ch, input wfMode_e mode, input logic [7:0] skip,
                             input logic doWe, input logic doArm);
        cfgCh   = CW'(ch);
        cfgMode = mode;
        cfgSkip = skip;
        cfgWe   = doWe;
        arm     = doArm;
        tick();
        cfgWe   = 1'b0;
        arm     = 1'b0;
    endtask

    function automatic logic [AW-1:0] ptrOf(input int ch);
        return wrPtrAll[ch*AW +: AW];
    endfunction

    // Back-to-back reads over a slice of the vector table.
    task automatic runReads(input int first, input int last);
        for (int v = first; v <= last; v++) begin
            rdEn   = 1'b1;
            rdCh   = vecs[v].ch;
            rdAddr = vecs[v].addr;
            tick();
            checkOutput($sformatf("rd ch%0d[%0d]", vecs[v].ch, vecs[v].addr),
                        64'(rdData), 64'(vecs[v].expData));
            checkOutput($sformatf("rd_valid ch%0d[%0d]", vecs[v].ch, vecs[v].addr),
                        64'(rdValid), 64'(1));
        end
        rdEn = 1'b0;
    endtask

    initial begin
        logic [2*IW-1:0] lastData;
        logic            inRange;

        // ch0 one-shot capture: I=k, Q=-k
        for (int k = 0; k < 16; k++) begin
            vecs[k].ch      = 2'd0;
            vecs[k].addr    = AW'(k);
            vecs[k].expData = {16'(k), 16'(-k)};
        end
        // ch1 continuous ring after 40 samples: newest of each address
        for (int k = 0; k < 8; k++) begin
            vecs[16+k].ch      = 2'd1;
            vecs[16+k].addr    = AW'(k + 8);
            vecs[16+k].expData = {16'(24 + k), 16'(16'h1000 + 24 + k)};
        end
        vecs[24].ch = 2'd1; vecs[24].addr = 4'd0; vecs[24].expData = {16'd32, 16'h1020};
        // ch2 sync capture with skip=2 starting at n=5
        for (int k = 0; k < 4; k++) begin
            vecs[25+k].ch      = 2'd2;
            vecs[25+k].addr    = AW'(k);
            vecs[25+k].expData = {16'(5 + 3*k), 16'(16'h2000 + 5 + 3*k)};
        end

        rstN = 1'b0; inStrobe = '0; inI = '0; inQ = '0; cfgWe = 1'b0; cfgCh = '0;
        cfgMode = '0; cfgSkip = '0; arm = 1'b0; syncIn = 1'b0; rdEn = 1'b0;
        rdCh = '0; rdAddr = '0;
        tick();
        tick();
        rstN = 1'b1;
        tick();

        $display("[TB] reset state");
        checkOutput("reset full", 64'(full), 64'(0));
        checkOutput("reset overrun", 64'(overrun), 64'(0));
        checkOutput("reset wr_ptr_all", 64'(wrPtrAll), 64'(0));
        checkOutput("reset rd_valid", 64'(rdValid), 64'(0));
        checkOutput("reset rd_data", 64'(rdData), 64'(0));

        $display("[TB] ch0 one-shot");
        configure(0, WF_MODE_ONESHOT, 8'd0, 1'b1, 1'b1);
        for (int n = 0; n < 15; n++) applyStimulus(4'b0001, 16'(n), 16'(-n), 1'b0, 4);
        checkOutput("ch0 ptr after 15", 64'(ptrOf(0)), 64'(15));
        checkOutput("ch0 not yet full", 64'(full[0]), 64'(0));
        for (int n = 15; n < 20; n++) applyStimulus(4'b0001, 16'(n), 16'(-n), 1'b0, 4);
        checkOutput("ch0 full", 64'(full[0]), 64'(1));
        checkOutput("ch0 ptr wrapped", 64'(ptrOf(0)), 64'(0));
        checkOutput("ch0 no overrun", 64'(overrun[0]), 64'(0));

        $display("[TB] ch1 continuous");
        configure(1, WF_MODE_CONTIN, 8'd0, 1'b1, 1'b0);
        applyStimulus(4'b0010, 16'd99, 16'd99, 1'b0, 4);
        checkOutput("ch1 cfg_we alone idle", 64'(ptrOf(1)), 64'(0));
        configure(1, WF_MODE_OFF, 8'd0, 1'b0, 1'b1);
        for (int n = 0; n < 40; n++)
            applyStimulus(4'b0010, 16'(n), 16'(16'h1000 + n), 1'b0, 4);
        checkOutput("ch1 ptr", 64'(ptrOf(1)), 64'(8));
        checkOutput("ch1 full", 64'(full[1]), 64'(0));

        $display("[TB] back-to-back reads");
        runReads(0, 24);
        tick();
        checkOutput("rd_valid drops", 64'(rdValid), 64'(0));
        checkOutput("rd_data holds", 64'(rdData), 64'(vecs[24].expData));

        $display("[TB] read/write collision");
        applyStimulus(4'b0010, 16'd40, 16'h1028, 1'b0, 1);
        rdEn = 1'b1; rdCh = 2'd1; rdAddr = 4'd8;
        tick();
        checkOutput("collision old data", 64'(rdData), 64'({16'd24, 16'h1018}));
        tick();
        checkOutput("collision new data", 64'(rdData), 64'({16'd40, 16'h1028}));
        rdEn = 1'b0;
        checkOutput("ch1 ptr after collision", 64'(ptrOf(1)), 64'(9));

        $display("[TB] ch2 sync with skip");
        configure(2, WF_MODE_SYNC, 8'd2, 1'b1, 1'b1);
        for (int n = 0; n < 5; n++)
            applyStimulus(4'b0100, 16'(n), 16'(16'h2000 + n), 1'b0, 4);
        checkOutput("ch2 waits for sync", 64'(ptrOf(2)), 64'(0));
        for (int n = 5; n < 20; n++)
            applyStimulus(4'b0100, 16'(n), 16'(16'h2000 + n), n == 5, 4);
        checkOutput("ch2 ptr", 64'(ptrOf(2)), 64'(5));
        runReads(25, 28);

        $display("[TB] reset mid-fill");
        configure(3, WF_MODE_ONESHOT, 8'd0, 1'b1, 1'b1);
        for (int n = 0; n < 3; n++) applyStimulus(4'b1000, 16'(n), 16'(n), 1'b0, 4);
        checkOutput("ch3 ptr before reset", 64'(ptrOf(3)), 64'(3));
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        checkOutput("mid reset full", 64'(full), 64'(0));
        checkOutput("mid reset overrun", 64'(overrun), 64'(0));
        checkOutput("mid reset wr_ptr_all", 64'(wrPtrAll), 64'(0));
        checkOutput("mid reset rd_valid", 64'(rdValid), 64'(0));
        checkOutput("mid reset rd_data", 64'(rdData), 64'(0));
        for (int n = 0; n < 3; n++) applyStimulus(4'b1111, 16'(n), 16'(n), 1'b0, 1);
        tick();
        checkOutput("idle after reset ptrs", 64'(wrPtrAll), 64'(0));
        checkOutput("idle after reset overrun", 64'(overrun), 64'(0));

        $display("[TB] all channels every cycle");
        for (int c = 0; c < NCH; c++) configure(c, WF_MODE_CONTIN, 8'd0, 1'b1, 1'b1);
        for (int n = 0; n < 16; n++) applyStimulus(4'b1111, 16'(n), 16'(n), 1'b0, 1);
        for (int g = 0; g < 8; g++) tick();
        checkOutput("dense overrun", 64'(overrun), 64'(4'hF));
        checkOutput("dense full", 64'(full), 64'(0));
        for (int c = 0; c < NCH; c++) begin
            inRange = (ptrOf(c) >= 4) && (ptrOf(c) <= 5);
            checkOutput($sformatf("dense ch%0d 1-of-4 written", c), 64'(inRange), 64'(1));
        end

        $display("[TB] all channels spacing 4");
        for (int c = 0; c < NCH; c++) configure(c, WF_MODE_CONTIN, 8'd0, 1'b0, 1'b1);
        checkOutput("re-arm clears overrun", 64'(overrun), 64'(0));
        for (int n = 0; n < 6; n++) applyStimulus(4'b1111, 16'(n), 16'(n), 1'b0, 4);
        for (int g = 0; g < 8; g++) tick();
        checkOutput("spaced overrun", 64'(overrun), 64'(0));
        checkOutput("spaced ptrs", 64'(wrPtrAll), 64'({4'd6, 4'd6, 4'd6, 4'd6}));

        lastData = {16'd3, 16'd3};
        rdEn = 1'b1; rdCh = 2'd3; rdAddr = 4'd3;
        tick();
        rdEn = 1'b0;
        checkOutput("spaced ch3[3]", 64'(rdData), 64'(lastData));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
